// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_pkg
//  Description : Shared constants for the CP0 exception unit: exception
//                codes, CP0 register numbers, Status/Cause bit positions,
//                MTC0 write masks and the fixed-priority exception selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

    // Exception codes written to Cause.ExcCode
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // CP0 register numbers
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // Status bit positions
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_IM_HI = 15;

    // Cause bit positions
    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;
    localparam int CA_IP_LO  = 8;
    localparam int CA_IP_HI  = 15;
    localparam int CA_TI     = 30;
    localparam int CA_BD     = 31;

    // Bits of Status that MTC0 may change: IM[15:8], EXL, IE
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    typedef struct packed {
        logic       taken;      // some source won arbitration
        logic [4:0] code;       // ExcCode of the winner
        logic       bad_fetch;  // BadVAddr <- fetch PC
        logic       bad_data;   // BadVAddr <- data address
    } exc_sel_t;

    // Fixed-priority arbitration, highest priority first.
    function automatic exc_sel_t exc_select(
        input logic int_req,
        input logic adel_fetch,
        input logic reserved_inst,
        input logic overflow,
        input logic syscall,
        input logic break_inst,
        input logic adel_load,
        input logic ades_store
    );
        exc_sel_t s;
        s = '{taken: 1'b1, code: EXC_INT, bad_fetch: 1'b0, bad_data: 1'b0};
        if (int_req)            s.code = EXC_INT;
        else if (adel_fetch)    begin s.code = EXC_ADEL; s.bad_fetch = 1'b1; end
        else if (reserved_inst) s.code = EXC_RI;
        else if (overflow)      s.code = EXC_OV;
        else if (syscall)       s.code = EXC_SYS;
        else if (break_inst)    s.code = EXC_BP;
        else if (adel_load)     begin s.code = EXC_ADEL; s.bad_data = 1'b1; end
        else if (ades_store)    begin s.code = EXC_ADES; s.bad_data = 1'b1; end
        else                    s.taken = 1'b0;
        return s;
    endfunction

endpackage : cp0_pkg
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_timer
//  Description : CP0 Count/Compare timer. Count advances every second clock,
//                TI is sticky once Count equals Compare and is cleared only
//                by a write to Compare.
//  Ports       : clk, resetn         - clock, synchronous active-low reset
//                count_we_i          - load Count from wdata_i, clear toggle
//                compare_we_i        - load Compare from wdata_i, clear TI
//                wdata_i             - write data
//                count_o, compare_o  - current register values
//                ti_o                - timer interrupt flag
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        toggle_q, toggle_d;
    logic        ti_q, ti_d;

    always_comb begin
        toggle_d  = ~toggle_q;
        count_d   = toggle_q ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        // The match uses the values held this cycle; a Compare write wins.
        ti_d      = ti_q | (count_q == compare_q);
        if (count_we_i) begin
            count_d  = wdata_i;
            toggle_d = 1'b0;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            toggle_q  <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            toggle_q  <= toggle_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule : cp0_timer
`default_nettype wire

// File: rtl/exc_cp0_unit.sv
`default_nettype none
// ============================================================================
//  Module      : exc_cp0_unit
//  Description : MEM-stage exception arbiter with CP0 state (Status, Cause,
//                EPC, BadVAddr, Count, Compare). Takes exceptions and masked
//                interrupts, handles ERET and MTC0/MFC0, redirects fetch.
//  Ports       : clk, resetn                 - clock, sync active-low reset
//                pc_i, in_delay_slot_i       - MEM instruction PC / BD flag
//                fetch_pc_i, data_vaddr_i    - candidate BadVAddr values
//                adel_fetch_i .. ades_store_i - exception flags
//                hw_int_i                    - level external interrupts
//                eret_i                      - ERET in MEM
//                mtc0_we_i, cp0_addr_i, mtc0_wdata_i - CP0 access
//                mfc0_rdata_o                - combinational CP0 read
//                exc_flush_o, exc_target_o   - pipeline flush / redirect
//                status_o, cause_o, epc_o    - current register values
//  Revision    : 1.0 - initial release
// ============================================================================
module exc_cp0_unit
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_INT = 6,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000,
    parameter int          TIMER_EN   = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [31:0]           pc_i,
    input  logic                  in_delay_slot_i,
    input  logic [31:0]           fetch_pc_i,
    input  logic [31:0]           data_vaddr_i,
    input  logic                  adel_fetch_i,
    input  logic                  reserved_inst_i,
    input  logic                  overflow_i,
    input  logic                  syscall_i,
    input  logic                  break_inst_i,
    input  logic                  adel_load_i,
    input  logic                  ades_store_i,
    input  logic [NUM_HW_INT-1:0] hw_int_i,
    input  logic                  eret_i,
    input  logic                  mtc0_we_i,
    input  logic [4:0]            cp0_addr_i,
    input  logic [31:0]           mtc0_wdata_i,
    output logic [31:0]           mfc0_rdata_o,
    output logic                  exc_flush_o,
    output logic [31:0]           exc_target_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o
);

    // Registered state; Cause is kept as its individual writable fields.
    logic [31:0] status_q,   status_d;
    logic [31:0] epc_q,      epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        bd_q,       bd_d;
    logic [4:0]  exccode_q,  exccode_d;
    logic [1:0]  ip_sw_q,    ip_sw_d;
    logic [5:0]  ip_hw_q,    ip_hw_d;

    logic [31:0] w_count, w_compare;
    logic        w_ti;
    logic [31:0] w_cause;
    logic        w_int_req;
    exc_sel_t    w_sel;
    logic        w_mtc0_ok;

    // External lines zero-extended onto IP[7:2]
    always_comb begin
        ip_hw_d                 = 6'd0;
        ip_hw_d[NUM_HW_INT-1:0] = hw_int_i;
    end

    assign w_cause = {bd_q, w_ti, 14'd0,
                      ip_hw_q[5] | w_ti, ip_hw_q[4:0],
                      ip_sw_q, 1'b0, exccode_q, 2'b00};

    assign w_int_req = status_q[ST_IE] & ~status_q[ST_EXL] &
                       (|(w_cause[CA_IP_HI:CA_IP_LO] & status_q[ST_IM_HI:ST_IM_LO]));

    assign w_sel = exc_select(w_int_req, adel_fetch_i, reserved_inst_i, overflow_i,
                              syscall_i, break_inst_i, adel_load_i, ades_store_i);

    // An exception in the same cycle drops any CP0 write entirely.
    assign w_mtc0_ok = mtc0_we_i & ~w_sel.taken;

    assign exc_flush_o  = resetn & (w_sel.taken | eret_i);
    assign exc_target_o = w_sel.taken ? EXC_VECTOR : epc_q;

    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;
        if (w_sel.taken) begin
            exccode_d        = w_sel.code;
            status_d[ST_EXL] = 1'b1;
            // A nested exception keeps the original return address.
            if (!status_q[ST_EXL]) begin
                epc_d = in_delay_slot_i ? pc_i - 32'd4 : pc_i;
                bd_d  = in_delay_slot_i;
            end
            if (w_sel.bad_fetch)     badvaddr_d = fetch_pc_i;
            else if (w_sel.bad_data) badvaddr_d = data_vaddr_i;
        end else begin
            if (eret_i) status_d[ST_EXL] = 1'b0;
            if (w_mtc0_ok) begin
                case (cp0_addr_i)
                    CP0_STATUS: status_d = (status_q & ~STATUS_WMASK) |
                                           (mtc0_wdata_i & STATUS_WMASK);
                    CP0_CAUSE:  ip_sw_d  = mtc0_wdata_i[CA_IP_LO+1:CA_IP_LO];
                    CP0_EPC:    epc_d    = mtc0_wdata_i;
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            status_q   <= STATUS_RST;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            bd_q       <= 1'b0;
            exccode_q  <= 5'd0;
            ip_sw_q    <= 2'd0;
            ip_hw_q    <= 6'd0;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
        end
    end

    generate
        if (TIMER_EN != 0) begin : g_timer
            cp0_timer u_timer (
                .clk          (clk),
                .resetn       (resetn),
                .count_we_i   (w_mtc0_ok && cp0_addr_i == CP0_COUNT),
                .compare_we_i (w_mtc0_ok && cp0_addr_i == CP0_COMPARE),
                .wdata_i      (mtc0_wdata_i),
                .count_o      (w_count),
                .compare_o    (w_compare),
                .ti_o         (w_ti)
            );
        end else begin : g_no_timer
            assign w_count   = 32'd0;
            assign w_compare = 32'd0;
            assign w_ti      = 1'b0;
        end
    endgenerate

    always_comb begin
        case (cp0_addr_i)
            CP0_BADVADDR: mfc0_rdata_o = badvaddr_q;
            CP0_COUNT:    mfc0_rdata_o = w_count;
            CP0_COMPARE:  mfc0_rdata_o = w_compare;
            CP0_STATUS:   mfc0_rdata_o = status_q;
            CP0_CAUSE:    mfc0_rdata_o = w_cause;
            CP0_EPC:      mfc0_rdata_o = epc_q;
            default:      mfc0_rdata_o = 32'd0;
        endcase
    end

    assign status_o = status_q;
    assign cause_o  = w_cause;
    assign epc_o    = epc_q;

endmodule : exc_cp0_unit
`default_nettype wire

// File: tb/tb_exc_cp0_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exc_cp0_unit
//  Description : Directed self-checking bench for exc_cp0_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_cp0_unit;

    localparam logic [31:0] c_VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] pc_i, fetch_pc_i, data_vaddr_i, mtc0_wdata_i;
    logic        in_delay_slot_i;
    logic        adel_fetch_i, reserved_inst_i, overflow_i, syscall_i;
    logic        break_inst_i, adel_load_i, ades_store_i;
    logic [5:0]  hw_int_i;
    logic        eret_i, mtc0_we_i;
    logic [4:0]  cp0_addr_i;
    logic [31:0] mfc0_rdata_o, exc_target_o, status_o, cause_o, epc_o;
    logic        exc_flush_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    exc_cp0_unit dut (
        .clk             (clk),
        .resetn          (resetn),
        .pc_i            (pc_i),
        .in_delay_slot_i (in_delay_slot_i),
        .fetch_pc_i      (fetch_pc_i),
        .data_vaddr_i    (data_vaddr_i),
        .adel_fetch_i    (adel_fetch_i),
        .reserved_inst_i (reserved_inst_i),
        .overflow_i      (overflow_i),
        .syscall_i       (syscall_i),
        .break_inst_i    (break_inst_i),
        .adel_load_i     (adel_load_i),
        .ades_store_i    (ades_store_i),
        .hw_int_i        (hw_int_i),
        .eret_i          (eret_i),
        .mtc0_we_i       (mtc0_we_i),
        .cp0_addr_i      (cp0_addr_i),
        .mtc0_wdata_i    (mtc0_wdata_i),
        .mfc0_rdata_o    (mfc0_rdata_o),
        .exc_flush_o     (exc_flush_o),
        .exc_target_o    (exc_target_o),
        .status_o        (status_o),
        .cause_o         (cause_o),
        .epc_o           (epc_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        adel_fetch_i = 0; reserved_inst_i = 0; overflow_i = 0; syscall_i = 0;
        break_inst_i = 0; adel_load_i = 0; ades_store_i = 0;
        eret_i = 0; mtc0_we_i = 0; in_delay_slot_i = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we_i = 1; cp0_addr_i = a; mtc0_wdata_i = d;
        tick();
        mtc0_we_i = 0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr_i = a;
        #1;
        check(tag, mfc0_rdata_o, exp);
    endtask

    int n_wait;

    initial begin
        idle();
        resetn = 0; pc_i = 0; fetch_pc_i = 0; data_vaddr_i = 0;
        mtc0_wdata_i = 0; hw_int_i = 0; cp0_addr_i = 0;
        overflow_i = 1;                      // flag during reset must not flush
        tick(); tick();
        check("rst_flush", {31'd0, exc_flush_o}, 32'd0);
        check("rst_status", status_o, 32'h0040_0000);
        check("rst_cause", cause_o, 32'd0);
        check("rst_epc", epc_o, 32'd0);
        overflow_i = 0;
        resetn = 1;
        tick();

        // Overflow, not in delay slot
        overflow_i = 1; pc_i = 32'h1000; #1;
        check("ov_flush", {31'd0, exc_flush_o}, 32'd1);
        check("ov_target", exc_target_o, c_VEC);
        tick(); idle();
        check("ov_epc", epc_o, 32'h1000);
        check("ov_code", {27'd0, cause_o[6:2]}, 32'd12);
        check("ov_exl", {31'd0, status_o[1]}, 32'd1);
        check("ov_bd", {31'd0, cause_o[31]}, 32'd0);

        // ERET back to 0x1000
        eret_i = 1; #1;
        check("eret1_flush", {31'd0, exc_flush_o}, 32'd1);
        check("eret1_target", exc_target_o, 32'h1000);
        tick(); idle();
        check("eret1_exl", {31'd0, status_o[1]}, 32'd0);

        // Load address error in delay slot
        adel_load_i = 1; data_vaddr_i = 32'h2003; pc_i = 32'h2008; in_delay_slot_i = 1;
        tick(); idle();
        check("adel_epc", epc_o, 32'h2004);
        check("adel_bd", {31'd0, cause_o[31]}, 32'd1);
        check("adel_code", {27'd0, cause_o[6:2]}, 32'd4);
        rd("adel_badv", 5'd8, 32'h2003);

        // Syscall while EXL=1: EPC and BD held
        syscall_i = 1; pc_i = 32'h3000; #1;
        check("sys_target", exc_target_o, c_VEC);
        tick(); idle();
        check("sys_code", {27'd0, cause_o[6:2]}, 32'd8);
        check("sys_epc", epc_o, 32'h2004);
        check("sys_bd", {31'd0, cause_o[31]}, 32'd1);
        eret_i = 1; #1;
        check("eret2_target", exc_target_o, 32'h2004);
        tick(); idle();
        check("eret2_status", status_o, 32'h0040_0000);

        // BadVAddr is read-only; unimplemented register reads 0
        mtc0(5'd8, 32'hFFFF_FFFF);
        rd("badv_ro", 5'd8, 32'h2003);
        rd("unimpl_rd", 5'd3, 32'd0);

        // Hardware interrupt on line 0 with IM2 & IE
        mtc0(5'd12, 32'h0000_0401);
        check("st_write", status_o, 32'h0040_0401);
        hw_int_i = 6'b000001; pc_i = 32'h4000; #1;
        check("int_wait", {31'd0, exc_flush_o}, 32'd0);  // IP not sampled yet
        tick();
        check("int_flush", {31'd0, exc_flush_o}, 32'd1);
        check("int_target", exc_target_o, c_VEC);
        tick();
        check("int_code", {27'd0, cause_o[6:2]}, 32'd0);
        check("int_epc", epc_o, 32'h4000);
        check("int_exl_block", {31'd0, exc_flush_o}, 32'd0);
        hw_int_i = 0; eret_i = 1;
        tick(); idle();
        check("int_eret_exl", {31'd0, status_o[1]}, 32'd0);

        // Timer: Compare=5 clears TI, Count=0, wait for match
        mtc0(5'd11, 32'd5);
        check("ti_clr", {31'd0, cause_o[30]}, 32'd0);
        mtc0(5'd9, 32'd0);
        n_wait = 0;
        while (cause_o[30] !== 1'b1 && n_wait < 40) begin
            tick();
            n_wait++;
        end
        check("ti_latency", n_wait, 32'd11);
        rd("ti_count", 5'd9, 32'd5);
        rd("ti_compare", 5'd11, 32'd5);
        check("ti_ip7", {31'd0, cause_o[15]}, 32'd1);
        mtc0(5'd12, 32'h0000_8001);             // IM7 & IE
        pc_i = 32'h5000; #1;
        check("tint_flush", {31'd0, exc_flush_o}, 32'd1);
        tick();
        check("tint_code", {27'd0, cause_o[6:2]}, 32'd0);
        check("tint_epc", epc_o, 32'h5000);
        mtc0(5'd11, 32'h100);
        check("ti_clr2", {31'd0, cause_o[30]}, 32'd0);
        eret_i = 1; #1;
        check("eret3_target", exc_target_o, 32'h5000);
        tick(); idle();

        // Simultaneous RI + BREAK + MTC0 EPC + ERET
        mtc0(5'd12, 32'h0);                     // no interrupts enabled
        reserved_inst_i = 1; break_inst_i = 1; eret_i = 1; pc_i = 32'h6000;
        mtc0_we_i = 1; cp0_addr_i = 5'd14; mtc0_wdata_i = 32'hDEAD_0000; #1;
        check("sim_target", exc_target_o, c_VEC);
        tick(); idle();
        check("sim_code", {27'd0, cause_o[6:2]}, 32'd10);
        check("sim_epc", epc_o, 32'h6000);
        check("sim_exl", {31'd0, status_o[1]}, 32'd1);

        // MTC0 dropped under EXL=1 nested exception: EPC must stay 0x6000
        adel_fetch_i = 1; fetch_pc_i = 32'h7001;
        mtc0_we_i = 1; cp0_addr_i = 5'd14; mtc0_wdata_i = 32'h1234_5678;
        tick(); idle();
        check("drop_epc", epc_o, 32'h6000);
        check("afetch_code", {27'd0, cause_o[6:2]}, 32'd4);
        rd("afetch_badv", 5'd8, 32'h7001);

        // Reset during exception wins
        overflow_i = 1; resetn = 0; #1;
        check("rstx_flush", {31'd0, exc_flush_o}, 32'd0);
        tick(); idle();
        check("rstx_status", status_o, 32'h0040_0000);
        check("rstx_epc", epc_o, 32'd0);
        resetn = 1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_exc_cp0_unit
`default_nettype wire

// File: doc/exc_cp0_unit.md
Name: exc_cp0_unit

Overview:
Parametrised successor to the combinational exception decoder. It adds registered CP0 state: Status, Cause, EPC, BadVAddr, Count and Compare. It also adds masked hardware and timer interrupts, EXL nesting protection, ERET return, and MTC0/MFC0 access. It sits at the MEM stage, where it arbitrates exception sources, redirects fetch and flushes the pipeline.

Parameters:
NUM_HW_INT, 6, number of external interrupt lines (1..6), mapped to Cause.IP[2+NUM_HW_INT-1:2]
EXC_VECTOR, 32'hBFC00380, fetch target on any exception
STATUS_RST, 32'h0040_0000, Status reset value (BEV=1, EXL=0, IE=0, IM=0)
TIMER_EN, 1, 1 = Count/Compare timer present and drives IP7

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
pc  in  32  PC of the instruction in MEM
in_delay_slot  in  1  MEM instruction is in a branch delay slot
fetch_pc  in  32  PC used to fetch the MEM instruction
data_vaddr  in  32  load/store effective address
adel_fetch, reserved_inst, overflow, syscall, break_inst, adel_load, ades_store  in  1 each  exception flags
hw_int  in  NUM_HW_INT  level-sensitive external interrupts
eret  in  1  ERET in MEM
mtc0_we  in  1  MTC0 write enable
cp0_addr  in  5  MTC0/MFC0 register number
mtc0_wdata  in  32  MTC0 data
mfc0_rdata  out  32  combinational read of cp0_addr
exc_flush  out  1  flush IF..MEM and redirect fetch
exc_target  out  32  redirect address
status_out, cause_out, epc_out  out  32  current register values

Behaviour:
- Reset, synchronous on clk edge with resetn=0:
  - Status=STATUS_RST; Cause=0; EPC=0; BadVAddr=0; Count=0; Compare=0; count toggle=0.
  - exc_flush=0 while resetn=0.
- Interrupt pending int_req = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
  - Cause.IP[7:2] is re-sampled every cycle from hw_int, zero-extended.
  - IP7 = hw_int bit | Cause.TI when TIMER_EN.
  - IP[1:0] are software bits, written only by MTC0.
- Fixed priority, highest first, with ExcCode:
  - int_req 0; adel_fetch 4; reserved_inst 10; overflow 12; syscall 8; break_inst 9; adel_load 4; ades_store 5.
- Exception taken (any source) is combinational:
  - exc_flush=1 and exc_target=EXC_VECTOR in the same cycle.
  - CP0 updates on the next edge:
    - Cause.ExcCode = winning code.
    - Status.EXL=1.
    - If EXL was 0 before the exception: EPC = in_delay_slot ? pc-4 : pc, and Cause.BD = in_delay_slot.
    - If EXL was already 1: EPC and BD are unchanged.
    - BadVAddr = fetch_pc for adel_fetch; data_vaddr for adel_load/ades_store; unchanged for other sources.
- ERET with no exception pending:
  - exc_flush=1, exc_target=EPC.
  - Status.EXL cleared at the next edge.
- Simultaneous events:
  - Exception beats ERET; ERET has no effect.
  - Exception beats MTC0; the write is dropped entirely.
  - Several flags at once: only the highest-priority source is recorded.
- MTC0 writable fields (all others read-only, with writes ignored):
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8].
  - EPC (14): all bits. Count (9): all bits. Compare (11): all bits.
  - BadVAddr (8) is read-only.
- MFC0: mfc0_rdata is combinational from the current registers. Unimplemented addresses read 0. There is no bypass of a same-cycle MTC0.
- Timer (TIMER_EN=1):
  - Count increments every second clk (toggle bit) and wraps 0xFFFFFFFF->0.
  - Cause.TI is set when Count==Compare and stays set until an MTC0 to Compare clears it.
  - MTC0 to Count loads the value and clears the toggle bit.
  - TIMER_EN=0: Count and Compare read 0 and TI stays 0.
- exc_flush is a single-cycle pulse per event. The pipeline feeds bubbles next cycle, so no re-trigger occurs unless a flag remains asserted.
- Reset asserted mid-exception: reset wins, and all registers take their reset values.

Decomposition:
- Package cp0_pkg holds:
  - ExcCode localparams (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV).
  - CP0 register numbers (8, 9, 11, 12, 13, 14).
  - Status/Cause bit-position constants.
- One sub-module, cp0_timer: Count, Compare, toggle and TI generation, with load/clear inputs.

Test Plan:
- Reset, then overflow=1, pc=0x1000, in_delay_slot=0 -> same cycle exc_flush=1, exc_target=0xBFC00380; next cycle EPC=0x1000, ExcCode=12, EXL=1, BD=0.
- adel_load with data_vaddr=0x2003, pc=0x2008, in_delay_slot=1 -> EPC=0x2004, BD=1, BadVAddr=0x2003, ExcCode=4.
- syscall while EXL=1 -> flush to vector, ExcCode=8, EPC unchanged; then eret -> exc_target=EPC, EXL=0 next cycle.
- MTC0 Status=0x0000_0401 (IM2, IE), then hw_int[0]=1 -> interrupt taken, ExcCode=0; repeat with EXL=1 -> no flush.
- MTC0 Compare=5, Count=0 -> TI=1 after Count reaches 5 (about cycle 10); interrupt taken if IM7&IE; MTC0 Compare clears TI.
- Same cycle: reserved_inst + break_inst + mtc0_we to EPC + eret -> ExcCode=10, MTC0 dropped, exc_target=vector.
